dna_job_sequencer: RTL

Sequences DNA alignment jobs between the Xillybus stream FIFOs and the alignment engine. Pops one x-sequence and one y-sequence job, each a header plus payload, from the dna_x and dna_y FIFO read sides. Loads both into the engine's sequence memories, starts the engine and waits for completion. Writes a tag word and the score word into the score_out FIFO, and handles stream close, EOF, malformed headers and engine timeout.

---
 rtl/dna_job_sequencer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/dna_job_sequencer.sv
// Pops an x and a y job (header + payload) from the input FIFOs, loads them into the
// alignment engine, runs it, and writes {x_tag, y_tag} followed by the score to score_out.
module dna_job_sequencer #(
  parameter int SEQ_MAX_WORDS = 64,
  parameter int TIMEOUT       = 65535,
  localparam int AW = (SEQ_MAX_WORDS > 1) ? $clog2(SEQ_MAX_WORDS) : 1
) (
  input  logic          bus_clk_w,
  input  logic          bus_rst_n_w,
  input  logic [31:0]   x_data_w,
  input  logic [31:0]   y_data_w,
  input  logic          x_empty_w,
  input  logic          y_empty_w,
  output logic          x_rden_w,
  output logic          y_rden_w,
  input  logic          dna_x_open_w,
  input  logic          dna_y_open_w,
  input  logic          score_open_w,
  output logic          eng_load_valid_w,
  output logic          eng_load_sel_w,
  output logic [AW-1:0] eng_load_addr_w,
  output logic [31:0]   eng_load_data_w,
  output logic [15:0]   eng_x_len_w,
  output logic [15:0]   eng_y_len_w,
  output logic          eng_start_w,
  input  logic          eng_done_w,
  input  logic [31:0]   eng_score_w,
  output logic [31:0]   score_data_w,
  output logic          score_wren_w,
  input  logic          score_full_w,
  output logic          score_eof_w,
  output logic          busy_w,
  output logic          err_w,
  output logic [15:0]   job_count_w
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_X_HDR  = 4'd1;
  localparam logic [3:0] S_X_LOAD = 4'd2;
  localparam logic [3:0] S_Y_HDR  = 4'd3;
  localparam logic [3:0] S_Y_LOAD = 4'd4;
  localparam logic [3:0] S_START  = 4'd5;
  localparam logic [3:0] S_WAIT   = 4'd6;
  localparam logic [3:0] S_OUT0   = 4'd7;
  localparam logic [3:0] S_OUT1   = 4'd8;
  localparam logic [3:0] S_ERR    = 4'd9;

  logic [3:0]    state;
  logic          rd_pend;
  logic [15:0]   rem;
  logic [AW-1:0] addr;
  logic [15:0]   x_tag, y_tag, x_len, y_len, job_count;
  logic [31:0]   wait_cnt, score;

  logic        both_open, out_go;
  logic [31:0] hdr_data;
  logic [15:0] hdr_len;
  logic        hdr_bad;

  always_comb begin
    both_open = dna_x_open_w & dna_y_open_w;
    out_go    = !score_open_w || !score_full_w;
    hdr_data  = (state == S_Y_HDR) ? y_data_w : x_data_w;
    hdr_len   = hdr_data[15:0];
    hdr_bad   = (hdr_len == 16'd0) || (hdr_len > 16'(SEQ_MAX_WORDS));

    x_rden_w = both_open && !x_empty_w &&
               (((state == S_X_HDR) && !rd_pend) || ((state == S_X_LOAD) && (rem != 16'd0)));
    y_rden_w = both_open && !y_empty_w &&
               (((state == S_Y_HDR) && !rd_pend) || ((state == S_Y_LOAD) && (rem != 16'd0)));

    // A word still in flight when a stream closes is dropped rather than loaded.
    eng_load_sel_w   = (state == S_Y_LOAD);
    eng_load_valid_w = both_open && rd_pend && ((state == S_X_LOAD) || (state == S_Y_LOAD));
    eng_load_addr_w  = addr;
    eng_load_data_w  = '0;
    if (eng_load_valid_w) eng_load_data_w = eng_load_sel_w ? y_data_w : x_data_w;

    eng_x_len_w = x_len;
    eng_y_len_w = y_len;
    eng_start_w = (state == S_START);

    score_wren_w = ((state == S_OUT0) || (state == S_OUT1)) && score_open_w && !score_full_w;
    score_data_w = '0;
    if (state == S_OUT0) score_data_w = {x_tag, y_tag};
    if (state == S_OUT1) score_data_w = score;

    score_eof_w = (state == S_ERR) || ((state == S_IDLE) && !dna_x_open_w && x_empty_w);
    busy_w      = (state != S_IDLE);
    err_w       = (state == S_ERR);
    job_count_w = job_count;
  end

  always_ff @(posedge bus_clk_w or negedge bus_rst_n_w) begin
    if (!bus_rst_n_w) begin
      state     <= S_IDLE;
      rd_pend   <= 1'b0;
      rem       <= '0;
      addr      <= '0;
      x_tag     <= '0;
      y_tag     <= '0;
      x_len     <= '0;
      y_len     <= '0;
      job_count <= '0;
      wait_cnt  <= '0;
      score     <= '0;
    end else begin
      rd_pend <= x_rden_w | y_rden_w;
      if ((x_rden_w || y_rden_w) && ((state == S_X_LOAD) || (state == S_Y_LOAD)))
        rem <= rem - 16'd1;
      if (eng_load_valid_w) addr <= addr + AW'(1);

      case (state)
        S_IDLE: if (both_open) state <= S_X_HDR;
        S_X_HDR, S_Y_HDR: begin
          if (!both_open) begin
            state <= S_IDLE;
          end else if (rd_pend) begin
            rem  <= hdr_len;
            addr <= '0;
            if (state == S_X_HDR) begin
              x_tag <= hdr_data[31:16];
              x_len <= hdr_len;
              state <= hdr_bad ? S_ERR : S_X_LOAD;
            end else begin
              y_tag <= hdr_data[31:16];
              y_len <= hdr_len;
              state <= hdr_bad ? S_ERR : S_Y_LOAD;
            end
          end
        end
        // rem reaches zero only after the final read, so the load seen then is the last word.
        S_X_LOAD: begin
          if (!both_open) state <= S_IDLE;
          else if (eng_load_valid_w && (rem == 16'd0)) state <= S_Y_HDR;
        end
        S_Y_LOAD: begin
          if (!both_open) state <= S_IDLE;
          else if (eng_load_valid_w && (rem == 16'd0)) state <= S_START;
        end
        S_START: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        // ERR becomes visible exactly TIMEOUT cycles after the start pulse; done has priority.
        S_WAIT: begin
          wait_cnt <= wait_cnt + 32'd1;
          if (eng_done_w) begin
            score <= eng_score_w;
            state <= S_OUT0;
          end else if (wait_cnt == 32'(TIMEOUT - 2)) begin
            state <= S_ERR;
          end
        end
        S_OUT0: if (out_go) state <= S_OUT1;
        S_OUT1: begin
          if (out_go) begin
            job_count <= job_count + 16'd1;
            state     <= S_IDLE;
          end
        end
        S_ERR: if (!dna_x_open_w && !dna_y_open_w) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
